// File: rtl/tmds_channel_decoder_if.sv
// TMDS channel decoder bus: one raw deserialised word in, decoded symbol out.
interface tmds_channel_decoder_if;
    logic [9:0] raw_in;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       locked;
    logic [3:0] offset;

    modport master (
        output raw_in,
        input  de, ctrl, data, locked, offset
    );

    modport slave (
        input  raw_in,
        output de, ctrl, data, locked, offset
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment by bit-slip search on control-token
// runs, followed by control/data decode with a fixed 3-cycle pipeline.
module tmds_channel_decoder #(
    parameter int unsigned LOCK_TOKENS   = 8,
    parameter int unsigned SEARCH_WINDOW = 1024
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    tmds_channel_decoder_if.slave tmds
);
    localparam int unsigned RUN_W = $clog2(LOCK_TOKENS + 1);
    localparam int unsigned WIN_W = (SEARCH_WINDOW > 2) ? $clog2(SEARCH_WINDOW) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_TOKENS);
    localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic [9:0]       raw_prev;
    logic [9:0]       aligned;
    logic [19:0]      raw_shift;
    logic             is_tok;
    logic [1:0]       tok_ctrl;
    logic [7:0]       q;
    logic [7:0]       word_data;
    state_t           state_q, state_n;
    logic [3:0]       offset_q, offset_n;
    logic [RUN_W-1:0] run_cnt, run_n;
    logic [WIN_W-1:0] win_cnt, win_n;
    logic [1:0]       skip_cnt, skip_n;
    logic             tok_count;
    logic             run_ok;
    logic             win_exp;
    logic             dec_de;
    logic [1:0]       dec_ctrl;
    logic [7:0]       dec_data;
    logic             locked_w;

    assign raw_shift = {tmds.raw_in, raw_prev} >> offset_q;

    // Stages 1 and 2: hold the previous raw word and slice the aligned symbol.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            raw_prev <= '0;
            aligned  <= '0;
        end else begin
            raw_prev <= tmds.raw_in;
            aligned  <= raw_shift[9:0];
        end
    end

    // Classify the aligned word and undo the transition-minimised coding.
    always_comb begin
        is_tok   = 1'b0;
        tok_ctrl = 2'b00;
        case (aligned)
            10'b1101010100: begin is_tok = 1'b1; tok_ctrl = 2'b00; end
            10'b0010101011: begin is_tok = 1'b1; tok_ctrl = 2'b01; end
            10'b0101010100: begin is_tok = 1'b1; tok_ctrl = 2'b10; end
            10'b1010101011: begin is_tok = 1'b1; tok_ctrl = 2'b11; end
            default:        ;
        endcase
        q            = aligned[9] ? ~aligned[7:0] : aligned[7:0];
        word_data    = '0;
        word_data[0] = q[0];
        for (int unsigned i = 1; i < 8; i++) begin
            word_data[i] = aligned[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    // Stage 3: register the decoded symbol; ctrl holds across data words.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            dec_de   <= 1'b0;
            dec_ctrl <= 2'b00;
            dec_data <= '0;
        end else if (is_tok) begin
            dec_de   <= 1'b0;
            dec_ctrl <= tok_ctrl;
            dec_data <= '0;
        end else begin
            dec_de   <= 1'b1;
            dec_data <= word_data;
        end
    end

    // Alignment FSM state and counters.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q  <= SEARCH;
            offset_q <= '0;
            run_cnt  <= '0;
            win_cnt  <= '0;
            skip_cnt <= '0;
        end else begin
            state_q  <= state_n;
            offset_q <= offset_n;
            run_cnt  <= run_n;
            win_cnt  <= win_n;
            skip_cnt <= skip_n;
        end
    end

    // Token-run counting, window expiry and bit-slip; a run keeps the window
    // refreshed while saturated so long blanking never drops lock.
    always_comb begin
        tok_count = is_tok && (skip_cnt == 2'd0);
        run_ok    = tok_count && (run_cnt >= RUN_PRE);
        win_exp   = (win_cnt == WIN_LAST);
        state_n   = state_q;
        offset_n  = offset_q;
        skip_n    = (skip_cnt != 2'd0) ? skip_cnt - 2'd1 : 2'd0;
        win_n     = win_cnt + 1'b1;
        if (!tok_count) begin
            run_n = '0;
        end else if (run_cnt != RUN_MAX) begin
            run_n = run_cnt + 1'b1;
        end else begin
            run_n = run_cnt;
        end
        if (run_ok) begin
            state_n = LOCKED;
            win_n   = '0;
        end else if (win_exp) begin
            // Same slip action whether searching or falling out of lock.
            state_n  = SEARCH;
            offset_n = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            run_n    = '0;
            win_n    = '0;
            skip_n   = 2'd2;
        end
    end

    assign locked_w    = (state_q == LOCKED);
    assign tmds.locked = locked_w;
    assign tmds.de     = locked_w & dec_de;
    assign tmds.ctrl   = locked_w ? dec_ctrl : 2'b00;
    assign tmds.data   = locked_w ? dec_data : 8'h00;
    assign tmds.offset = offset_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, decode, token latency,
// run break, window expiry, asynchronous reset and rotated-stream search.
`timescale 1ns/100ps
module tb_tmds_channel_decoder;
    localparam int LT = 8;
    localparam int SW = 1024;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] DA5   = 10'h163; // XOR mode, no invert -> 0xA5
    localparam logic [9:0] D5A   = 10'h263; // XNOR mode, inverted -> 0x5A

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] prev_sym = '0;
    int         rot = 0;
    int         p = 0;

    tmds_channel_decoder_if bus();

    tmds_channel_decoder #(.LOCK_TOKENS(LT), .SEARCH_WINDOW(SW)) dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .tmds(bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic send_sym(input logic [9:0] s);
        logic [19:0] cat;
        cat = {s, prev_sym} >> (10 - rot);
        bus.raw_in = cat[9:0];
        prev_sym = s;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic send_stream(output int pos);
        pos = p;
        send_sym((p < 160) ? TOK00 : DA5);
        p = (p + 1) % 800;
    endtask

    task automatic do_reset();
        @(posedge clk_pixel);
        #1;
        reset = 1'b1;
        prev_sym = '0;
        p = 0;
        bus.raw_in = '0;
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.raw_in = '0;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.locked !== 1'b0 || bus.de !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags locked=%b de=%b want 0 0", bus.locked, bus.de);
        end
        checks++;
        if (bus.ctrl !== 2'b00 || bus.data !== 8'h00 || bus.offset !== 4'd0) begin
            errors++;
            $display("FAIL reset_values ctrl=%b data=%h offset=%0d want 00 00 0", bus.ctrl, bus.data, bus.offset);
        end
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_aligned();
        int pos;
        int lock_idx;
        lock_idx = -1;
        for (int i = 0; i < 800; i++) begin
            send_stream(pos);
            if (lock_idx < 0 && bus.locked === 1'b1) lock_idx = i;
            if (pos >= 2 && pos < 162) begin
                checks++;
                if (bus.de !== 1'b0 || bus.ctrl !== 2'b00) begin
                    errors++;
                    $display("FAIL aligned_blank pos=%0d de=%b ctrl=%b want 0 00", pos, bus.de, bus.ctrl);
                end
            end else if (pos >= 162) begin
                checks++;
                if (bus.de !== 1'b1 || bus.data !== 8'hA5) begin
                    errors++;
                    $display("FAIL aligned_data pos=%0d de=%b data=%h want 1 a5", pos, bus.de, bus.data);
                end
            end
        end
        checks++;
        if (lock_idx < LT - 1 || lock_idx > LT + 2) begin
            errors++;
            $display("FAIL aligned_lock_time idx=%0d want %0d..%0d", lock_idx, LT - 1, LT + 2);
        end
    endtask

    task automatic test_data_mix();
        logic [9:0] seq [12];
        logic       exp_de;
        logic [7:0] exp_data;
        seq = '{TOK00, TOK00, DA5, D5A, DA5, DA5, D5A, D5A, DA5, D5A, TOK00, TOK00};
        for (int i = 0; i < 20; i++) send_sym(TOK00);
        for (int j = 0; j < 12; j++) begin
            send_sym(seq[j]);
            if (j >= 2) begin
                exp_de = (seq[j-2] != TOK00);
                exp_data = (seq[j-2] == DA5) ? 8'hA5 : (seq[j-2] == D5A) ? 8'h5A : 8'h00;
                checks++;
                if (bus.de !== exp_de || bus.data !== exp_data || bus.ctrl !== 2'b00 || bus.locked !== 1'b1) begin
                    errors++;
                    $display("FAIL data_mix j=%0d de=%b data=%h ctrl=%b locked=%b want %b %h 00 1",
                             j, bus.de, bus.data, bus.ctrl, bus.locked, exp_de, exp_data);
                end
            end
        end
        for (int i = 0; i < 10; i++) send_sym(TOK00);
    endtask

    task automatic test_ctrl_tokens();
        logic [9:0] toks [4];
        int         idx;
        toks = '{TOK00, TOK01, TOK10, TOK11};
        for (int j = 0; j < 40; j++) begin
            send_sym(toks[j / 10]);
            idx = (j >= 2) ? (j - 2) / 10 : 0;
            checks++;
            if (bus.ctrl !== 2'(idx) || bus.de !== 1'b0 || bus.locked !== 1'b1) begin
                errors++;
                $display("FAIL ctrl_tokens j=%0d ctrl=%b de=%b locked=%b want %b 0 1",
                         j, bus.ctrl, bus.de, bus.locked, 2'(idx));
            end
        end
    endtask

    task automatic test_reset_midframe();
        int lock_idx;
        for (int i = 0; i < 100; i++) send_sym(DA5);
        checks++;
        if (bus.locked !== 1'b1 || bus.de !== 1'b1 || bus.data !== 8'hA5) begin
            errors++;
            $display("FAIL midreset_before locked=%b de=%b data=%h want 1 1 a5", bus.locked, bus.de, bus.data);
        end
        #2;
        reset = 1'b1;
        #0.5;
        checks++;
        if (bus.locked !== 1'b0 || bus.de !== 1'b0 || bus.data !== 8'h00 ||
            bus.ctrl !== 2'b00 || bus.offset !== 4'd0) begin
            errors++;
            $display("FAIL midreset_async locked=%b de=%b data=%h ctrl=%b offset=%0d want all 0",
                     bus.locked, bus.de, bus.data, bus.ctrl, bus.offset);
        end
        #0.5;
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send_sym(DA5);
            checks++;
            if (bus.locked !== 1'b0 || bus.de !== 1'b0 || bus.data !== 8'h00) begin
                errors++;
                $display("FAIL midreset_unlocked i=%0d locked=%b de=%b data=%h want 0 0 00",
                         i, bus.locked, bus.de, bus.data);
            end
        end
        lock_idx = -1;
        for (int i = 0; i < 160; i++) begin
            send_sym(TOK00);
            if (lock_idx < 0 && bus.locked === 1'b1) lock_idx = i;
        end
        checks++;
        if (lock_idx < LT - 1 || lock_idx > LT + 2 || bus.offset !== 4'd0) begin
            errors++;
            $display("FAIL midreset_relock idx=%0d offset=%0d want %0d..%0d 0", lock_idx, bus.offset, LT - 1, LT + 2);
        end
    endtask

    task automatic test_unlock();
        int fall_idx;
        fall_idx = -1;
        for (int i = 0; i < 1100; i++) begin
            send_sym(DA5);
            if (fall_idx < 0) begin
                if (bus.locked === 1'b0) begin
                    fall_idx = i;
                end else begin
                    checks++;
                    if (bus.offset !== 4'd0) begin
                        errors++;
                        $display("FAIL unlock_offset_held i=%0d offset=%0d want 0", i, bus.offset);
                    end
                end
            end else begin
                checks++;
                if (bus.locked !== 1'b0 || bus.de !== 1'b0 || bus.data !== 8'h00 || bus.ctrl !== 2'b00) begin
                    errors++;
                    $display("FAIL unlock_outputs i=%0d locked=%b de=%b data=%h ctrl=%b want 0 0 00 00",
                             i, bus.locked, bus.de, bus.data, bus.ctrl);
                end
            end
        end
        checks++;
        if (fall_idx != SW + 1) begin
            errors++;
            $display("FAIL unlock_time idx=%0d want %0d", fall_idx, SW + 1);
        end
        checks++;
        if (bus.offset !== 4'd1) begin
            errors++;
            $display("FAIL unlock_offset offset=%0d want 1", bus.offset);
        end
    endtask

    task automatic test_run_break();
        logic [9:0] s;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            s = (i < 7 || (i > 7 && i < 15)) ? TOK00 : DA5;
            send_sym(s);
            checks++;
            if (bus.locked !== 1'b0) begin
                errors++;
                $display("FAIL run_break i=%0d locked=%b want 0", i, bus.locked);
            end
        end
        for (int i = 0; i < 11; i++) send_sym(TOK00);
        checks++;
        if (bus.locked !== 1'b1 || bus.offset !== 4'd0) begin
            errors++;
            $display("FAIL run_break_full locked=%b offset=%0d want 1 0", bus.locked, bus.offset);
        end
    endtask

    task automatic test_rotated();
        int pos;
        int lock_n;
        do_reset();
        rot = 7;
        lock_n = -1;
        for (int n = 1; n <= 12000; n++) begin
            send_stream(pos);
            if (lock_n < 0) begin
                if (n % SW == SW / 2 && n < 7 * SW) begin
                    checks++;
                    if (bus.offset !== 4'(n / SW) || bus.locked !== 1'b0) begin
                        errors++;
                        $display("FAIL rot_step n=%0d offset=%0d locked=%b want %0d 0", n, bus.offset, bus.locked, n / SW);
                    end
                end
                if (bus.locked === 1'b1) begin
                    lock_n = n;
                    checks++;
                    if (bus.offset !== 4'd7 || n <= 7 * SW) begin
                        errors++;
                        $display("FAIL rot_lock n=%0d offset=%0d want 7 after %0d", n, bus.offset, 7 * SW);
                    end
                end
            end else begin
                if (pos >= 164) begin
                    checks++;
                    if (bus.de !== 1'b1 || bus.data !== 8'hA5 || bus.locked !== 1'b1) begin
                        errors++;
                        $display("FAIL rot_data pos=%0d de=%b data=%h locked=%b want 1 a5 1", pos, bus.de, bus.data, bus.locked);
                    end
                end else if (pos >= 4 && pos < 160) begin
                    checks++;
                    if (bus.de !== 1'b0 || bus.ctrl !== 2'b00) begin
                        errors++;
                        $display("FAIL rot_blank pos=%0d de=%b ctrl=%b want 0 00", pos, bus.de, bus.ctrl);
                    end
                end
                if (pos == 799) break;
            end
        end
        if (lock_n < 0) begin
            checks++;
            errors++;
            $display("FAIL rot_lock_timeout locked=%b offset=%0d want lock at 7", bus.locked, bus.offset);
        end
        rot = 0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_data_mix();
        test_ctrl_tokens();
        test_reset_midframe();
        test_unlock();
        test_run_break();
        test_rotated();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 Parameter LOCK_TOKENS, default 8: number of consecutive control tokens needed to declare or refresh alignment.
REQ-002 Parameter SEARCH_WINDOW, default 1024: number of cycles allowed per alignment offset without a qualifying token run.
REQ-003 Port clk_pixel, input, 1: pixel clock; all logic rises on its positive edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port raw_in, input, 10: one unaligned word per clk_pixel from the 1:10 deserializer; raw_in[0] is the earliest received bit.
REQ-006 Port de, output, 1: data-enable, high while the decoded word is a video data word.
REQ-007 Port ctrl, output, 2: control bits {c1,c0} carried by the most recent control token.
REQ-008 Port data, output, 8: decoded video byte.
REQ-009 Port locked, output, 1: word alignment established.
REQ-010 Port offset, output, 4: current bit-slip offset, range 0..9.

Function
REQ-011 Pipeline: stage 1 SHALL register raw_prev <= raw_in; stage 2 SHALL register aligned = bits [offset+9:offset] of the 20-bit value {raw_in, raw_prev}; stage 3 SHALL register de/ctrl/data.
REQ-012 Latency SHALL be exactly 3 clk_pixel cycles from the raw_in word that completes an aligned symbol to the corresponding outputs.
REQ-013 Control tokens SHALL decode as: 10'b1101010100 -> ctrl=00; 10'b0010101011 -> ctrl=01; 10'b0101010100 -> ctrl=10; 10'b1010101011 -> ctrl=11 (bit 9 leftmost).
REQ-014 On a control token: de=0, ctrl updated, data=0.
REQ-015 On any other word: de=1 and ctrl held; data SHALL be computed as follows.
- Let q = aligned[7:0] when aligned[9]=0, otherwise ~aligned[7:0].
- data[0] = q[0].
- For i=1..7: data[i] = q[i]^q[i-1] when aligned[8]=1, otherwise ~(q[i]^q[i-1]).
REQ-016 While locked=0: de, data and ctrl SHALL be forced to 0; the decode path keeps running.
REQ-017 The FSM SHALL have two states, SEARCH and LOCKED, with run counter run_cnt (saturating at LOCK_TOKENS) and window counter win_cnt.
REQ-018 run_cnt: increments on each stage-2 control token; clears on any non-token word.
REQ-019 win_cnt: increments every cycle; clears whenever run_cnt reaches LOCK_TOKENS and whenever offset changes.
REQ-020 SEARCH -> LOCKED when run_cnt reaches LOCK_TOKENS; locked rises on the same edge.
REQ-021 In SEARCH, when win_cnt reaches SEARCH_WINDOW-1 without a qualifying run: offset SHALL advance by one, wrapping 9 -> 0, and run_cnt and win_cnt SHALL clear.
REQ-022 LOCKED -> SEARCH when win_cnt reaches SEARCH_WINDOW-1 without a refreshing run; on that edge locked falls, offset advances by one with wrap, and run_cnt and win_cnt clear.
REQ-023 Simultaneous events: if run_cnt reaches LOCK_TOKENS on the same cycle win_cnt reaches SEARCH_WINDOW-1, the lock/refresh SHALL win and offset SHALL NOT change.
REQ-024 After an offset change, run_cnt SHALL ignore the 2 cycles whose stage-2 word was formed with the old offset.
REQ-025 Offset SHALL change only in SEARCH or on the LOCKED -> SEARCH transition, never while locked=1.

Reset
REQ-026 On reset=1, immediately and regardless of clock, the block SHALL set:
- state=SEARCH, offset=0, locked=0, de=0, ctrl=00, data=0;
- run_cnt=0, win_cnt=0, raw_prev=0, aligned=0.
REQ-027 Reset asserted mid-operation, including while LOCKED, SHALL discard alignment; search restarts at offset 0 on the first edge after release.

Verification
REQ-028 Aligned stream at true offset 0: 160 tokens 1101010100, then 640 data words encoding 0xA5, repeated. Required response:
- locked=1 within LOCK_TOKENS+3 cycles;
- afterwards de=1 and data=0xA5 during active words;
- ctrl=00 during blanking.
REQ-029 Same stream rotated by 7 bits. Required response: offset steps 0..7, one step per SEARCH_WINDOW cycles; locked=1 at offset 7; decoded data=0xA5.
REQ-030 Four token types in sequence, each held 10 cycles after lock. Required response: ctrl follows 00, 01, 10, 11 with exactly 3-cycle latency, and de=0 throughout.
REQ-031 After lock, replace the stream with continuous data words for 1100 cycles. Required response: locked falls at window expiry, offset becomes (old+1) mod 10, and de/data read 0 from then on.
REQ-032 Inject 7 tokens, then 1 data word, then 7 tokens. Required response: no lock, because run_cnt clears on the data word.
REQ-033 Pulse reset for 1 ns mid-frame while locked. Required response: all outputs 0 and offset=0 asynchronously; relock completes on the next blanking interval.
